regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters (ALU, load), the register-file
// write port and the forwarding query. The arbiter takes the slave side.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_dest;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_dest;
  logic [31:0] b_data;
  logic        b_ready;
  logic        clr_start;
  logic        busy;
  logic        wr_en;
  logic [4:0]  wr_dest;
  logic [31:0] wr_data;
  logic [4:0]  q_reg;
  logic        q_hit;
  logic [31:0] q_data;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, clr_start, q_reg,
    input  a_ready, b_ready, busy, wr_en, wr_dest, wr_data, q_hit, q_data
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, clr_start, q_reg,
    output a_ready, b_ready, busy, wr_en, wr_dest, wr_data, q_hit, q_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for a 32x32 register file with a clear
// sweep that zeroes registers 1..31 and a single-entry forwarding query.
module regfile_wb_arbiter (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t      state_q, state_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic        last_grant_q, last_grant_d;
  logic        busy_q, busy_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_dest_q, wr_dest_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic accept_open;
  logic a_acc;
  logic b_acc;

  // Grant decision: a clear request or reset closes the handshake window;
  // on contention the requester not granted last wins.
  always_comb begin
    accept_open = !reset && (state_q == IDLE) && !bus.clr_start;
    a_acc = accept_open && bus.a_valid && (!bus.b_valid || (last_grant_q == GRANT_B));
    b_acc = accept_open && bus.b_valid && (!bus.a_valid || (last_grant_q == GRANT_A));
  end

  assign bus.a_ready = a_acc;
  assign bus.b_ready = b_acc;
  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_dest = wr_dest_q;
  assign bus.wr_data = wr_data_q;
  assign bus.q_hit   = wr_en_q && (wr_dest_q == bus.q_reg) && (bus.q_reg != 5'd0);
  assign bus.q_data  = wr_data_q;

  // Next-state: accepted writes land one cycle later; the sweep presents
  // one cleared index per cycle and stops after 31 without wrapping.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    wr_en_d      = 1'b0;
    wr_dest_d    = wr_dest_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          clr_idx_d = 5'd1;
          wr_en_d   = 1'b1;
          wr_dest_d = 5'd1;
          wr_data_d = 32'd0;
        end else if (a_acc) begin
          last_grant_d = GRANT_A;
          wr_en_d      = (bus.a_dest != 5'd0);
          wr_dest_d    = bus.a_dest;
          wr_data_d    = bus.a_data;
        end else if (b_acc) begin
          last_grant_d = GRANT_B;
          wr_en_d      = (bus.b_dest != 5'd0);
          wr_dest_d    = bus.b_dest;
          wr_data_d    = bus.b_data;
        end
      end
      CLEAR: begin
        if (clr_idx_q == 5'd31) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          clr_idx_d = 5'd0;
        end else begin
          clr_idx_d = clr_idx_q + 5'd1;
          wr_en_d   = 1'b1;
          wr_dest_d = clr_idx_q + 5'd1;
          wr_data_d = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      clr_idx_q    <= 5'd0;
      last_grant_q <= GRANT_B;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_dest_q    <= 5'd0;
      wr_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_dest_q    <= wr_dest_d;
      wr_data_q    <= wr_data_d;
    end
  end

endmodule
